// File: rtl/fifo_tx_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_START = 3'd3,
      ST_DATA  = 3'd4,
      ST_STOP  = 3'd5
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, ticks on the last count.
module bit_timer
   import fifo_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = width_of(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   assign tick = run && (count == LAST);

   // Free-running period counter, held at zero whenever no frame bit is being timed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!run || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_serial_tx.sv
// Serial transmitter that drains a FIFO: fetch one byte, send start/data/stop.
// tx is registered from the state, so the line trails the FSM by one cycle;
// tx_done is registered the same way and lands on the last stop-bit cycle on the line.
module fifo_serial_tx
   import fifo_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DATA_W       = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done
);

   localparam int unsigned IW = width_of(DATA_W);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] shreg;
   logic [IW-1:0]     bit_idx;
   logic              tick;
   logic              run;
   logic              tx_next;
   logic              done_next;

   assign run = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);

   // busy also spans the tx_done cycle so it covers the stop bit as seen on the line.
   assign busy = (state != ST_IDLE) || tx_done;

   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .tick  (tick)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, read strobe and next line level.
   always_comb begin
      state_next = state;
      fifo_rd_en = 1'b0;
      tx_next    = STOP_BIT;
      done_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            fifo_rd_en = 1'b1;
            state_next = ST_LOAD;
         end
         ST_LOAD: begin
            state_next = ST_START;
         end
         ST_START: begin
            tx_next = START_BIT;
            if (tick) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_next = shreg[0];
            if (tick && (bit_idx == LAST_BIT)) begin
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            tx_next = STOP_BIT;
            if (tick) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Line register, done pulse, shift register and bit index.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx      <= STOP_BIT;
         tx_done <= 1'b0;
         shreg   <= '0;
         bit_idx <= '0;
      end else begin
         tx      <= tx_next;
         tx_done <= done_next;
         if (state == ST_LOAD) begin
            shreg   <= fifo_data;
            bit_idx <= '0;
         end else if ((state == ST_DATA) && tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Self-checking bench for fifo_serial_tx: FIFO model, line decoder with scoreboard,
// table-driven frame vectors and hand-written multi-cycle sequences.
module tb_fifo_serial_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;
   logic       tx;
   logic       busy;
   logic       tx_done;

   // second instance at one clock per bit
   logic       enable1;
   logic       fifo_empty1;
   logic [7:0] fifo_data1;
   logic       fifo_rd_en1;
   logic       tx1;
   logic       busy1;
   logic       tx_done1;

   fifo_serial_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   fifo_serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable1),
      .fifo_empty (fifo_empty1),
      .fifo_data  (fifo_data1),
      .fifo_rd_en (fifo_rd_en1),
      .tx         (tx1),
      .busy       (busy1),
      .tx_done    (tx_done1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // FIFO model: registered read data, one cycle after the strobe
   logic [7:0] mem [16];
   int         wp = 0;
   int         rp = 0;
   logic [7:0] sb [$];

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd_en && (wp != rp)) begin
         fifo_data <= mem[rp % 16];
         rp        <= rp + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      mem[wp % 16] = b;
      wp++;
      sb.push_back(b);
   endtask

   // Line decoder and activity counters
   int         rd_cnt    = 0;
   int         rd1_cnt   = 0;
   int         rd_viol   = 0;
   int         done_cnt  = 0;
   int         busy_run  = 0;
   int         last_busy = 0;
   int         hr        = 0;
   int         last_gap  = 0;
   bit         mact      = 0;
   int         cyc       = 0;
   int         glitch    = 0;
   logic       cur       = 1'b1;
   logic [7:0] byt       = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (fifo_rd_en === 1'b1) rd_cnt++;
         if (fifo_rd_en1 === 1'b1) rd1_cnt++;
         if (fifo_rd_en === 1'b1 && wp == rp) rd_viol++;
         if (!reset && tx_done === 1'b1) done_cnt++;
         if (busy === 1'b1) busy_run++;
         else if (busy_run > 0) begin
            last_busy = busy_run;
            busy_run  = 0;
         end
         if (reset) begin
            mact = 0;
            hr   = 0;
         end else if (!mact) begin
            if (tx === 1'b0) begin
               mact     = 1;
               cyc      = 1;
               last_gap = hr;
               hr       = 0;
               glitch   = 0;
               cur      = 1'b0;
               byt      = '0;
            end else begin
               hr++;
            end
         end else begin
            if (cyc % CPB == 0) begin
               cur = tx;
               if (cyc / CPB >= 1 && cyc / CPB <= 8) byt[cyc / CPB - 1] = tx;
            end else if (tx !== cur) begin
               glitch++;
            end
            if (cyc == 10 * CPB - 1) begin
               chk("stop_bit", int'(cur), 1);
               chk("tx_done_at_stop", int'(tx_done), 1);
               chk("frame_glitch", glitch, 0);
               if (sb.size() == 0) chk("unexpected_frame", 1, 0);
               else chk("rx_byte", int'(byt), int'(sb.pop_front()));
               mact = 0;
            end else begin
               if (tx_done === 1'b1) glitch++;
               cyc++;
            end
         end
      end
   end

   task automatic wait_tx_low(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (tx !== 1'b0 && lat < 200);
      if (tx !== 1'b0) chk("start_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_timeout", 1, 0);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int         lat;
      int         rd0;
      int         dn0;
      int         viol;
      logic [9:0] fr;
      logic [7:0] junk;

      vecs[0] = '{data: 8'hA1, frame: 10'b1101000010};
      vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
      vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
      vecs[3] = '{data: 8'h96, frame: 10'b1100101100};

      reset       = 1'b1;
      enable      = 1'b0;
      enable1     = 1'b1;
      fifo_empty1 = 1'b1;
      fifo_data1  = 8'h55;
      fifo_data   = 8'h00;

      // reset state
      #1;
      chk("rst_tx", int'(tx), 1);
      chk("rst_rd_en", int'(fifo_rd_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tx_done", int'(tx_done), 0);
      repeat (3) @(negedge clk);

      // first read after reset release
      enable = 1'b1;
      push(8'h3C);
      rd0 = rd_cnt;
      reset = 1'b0;
      #1 chk("rel_rd_en_before_edge", int'(fifo_rd_en), 0);
      @(negedge clk);
      chk("rel_rd_en_first_cycle", int'(fifo_rd_en), 1);
      wait_idle();
      @(negedge clk);
      chk("rel_rd_count", rd_cnt - rd0, 1);

      // table-driven single frames
      for (int i = 0; i < 4; i++) begin
         repeat (5) @(negedge clk);
         rd0 = rd_cnt;
         fr  = vecs[i].frame;
         push(vecs[i].data);
         wait_tx_low(lat);
         chk("start_latency", lat, 4);
         for (int c = 0; c < 10 * CPB; c++) begin
            chk("frame_tx", int'(tx), int'(fr[c / CPB]));
            @(negedge clk);
         end
         wait_idle();
         @(negedge clk);
         chk("rd_pulses", rd_cnt - rd0, 1);
         chk("busy_len", last_busy, 43);
      end

      // empty FIFO with enable high
      viol = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      chk("empty_idle", viol, 0);

      // back-to-back frames
      rd0 = rd_cnt;
      push(8'hB2);
      push(8'hC3);
      wait_tx_low(lat);
      repeat (10 * CPB + 1) @(negedge clk);
      wait_tx_low(lat);
      chk("b2b_gap", last_gap, 3);
      wait_idle();
      @(negedge clk);
      chk("b2b_rd_pulses", rd_cnt - rd0, 2);

      // enable dropped mid-frame
      repeat (5) @(negedge clk);
      rd0 = rd_cnt;
      push(8'hD4);
      push(8'hE5);
      wait_tx_low(lat);
      repeat (12) @(negedge clk);
      enable = 1'b0;
      wait_idle();
      repeat (30) @(negedge clk);
      chk("hold_rd_pulses", rd_cnt - rd0, 1);
      chk("hold_pending", wp - rp, 1);
      chk("hold_busy", int'(busy), 0);
      enable = 1'b1;
      wait_tx_low(lat);
      wait_idle();
      @(negedge clk);
      chk("resume_rd_pulses", rd_cnt - rd0, 2);

      // reset during data bit 3
      repeat (5) @(negedge clk);
      rd0 = rd_cnt;
      push(8'hF6);
      push(8'h17);
      wait_tx_low(lat);
      repeat (4 * CPB + 1) @(negedge clk);
      chk("pre_reset_tx", int'(tx), 0);
      dn0 = done_cnt;
      reset = 1'b1;
      #1;
      chk("mid_rst_tx", int'(tx), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_tx_done", int'(tx_done), 0);
      chk("mid_rst_rd_en", int'(fifo_rd_en), 0);
      junk = sb.pop_front();
      @(negedge clk);
      reset = 1'b0;
      wait_tx_low(lat);
      wait_idle();
      @(negedge clk);
      chk("after_rst_done", done_cnt - dn0, 1);
      chk("after_rst_rd_pulses", rd_cnt - rd0, 2);
      chk("after_rst_sb_empty", sb.size(), 0);
      chk("rd_on_empty", rd_viol, 0);

      // one clock per bit, byte 0x55
      fr  = 10'b1010101010;
      rd0 = rd1_cnt;
      fifo_empty1 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         fifo_empty1 = 1'b1;
      end while (tx1 !== 1'b0 && lat < 50);
      chk("cpb1_latency", lat, 4);
      for (int c = 0; c < 10; c++) begin
         chk("cpb1_tx", int'(tx1), int'(fr[c]));
         chk("cpb1_tx_done", int'(tx_done1), (c == 9) ? 1 : 0);
         @(negedge clk);
      end
      chk("cpb1_idle_tx", int'(tx1), 1);
      chk("cpb1_rd_pulses", rd1_cnt - rd0, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 1..65535.
REQ-002 Parameter DATA_W, default 8: byte width read from the FIFO and sent per frame.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  permits new frames to start; high = drain FIFO.
REQ-006 fifo_empty  input  1  FIFO read-side empty flag.
REQ-007 fifo_data  input  DATA_W  FIFO read data; valid the cycle after a fifo_rd_en cycle.
REQ-008 fifo_rd_en  output  1  one-cycle FIFO read strobe.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 busy  output  1  high while a fetch or frame is in progress.
REQ-011 tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-013 IDLE: if enable=1 and fifo_empty=0, go to FETCH; otherwise stay, with tx=1.
REQ-014 FETCH: fifo_rd_en=1 for exactly this one cycle; go to LOAD.
REQ-015 LOAD: capture fifo_data into the shift register; go to START.
REQ-016 Frame format: one start bit (0), DATA_W data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-017 tx SHALL be registered; tx falls 3 clocks after the edge that sampled fifo_empty=0 in IDLE.
REQ-018 The bit timer counts 0..CLKS_PER_BIT-1.
REQ-019 The bit index counts 0..DATA_W-1 in DATA.
REQ-020 STOP -> IDLE transition: pulse tx_done for one cycle.
REQ-021 Back-to-back frames: IDLE re-evaluates on the next edge, so there are exactly 3 tx-high cycles between the stop bit and the next start bit.
REQ-022 busy=1 in every state except IDLE.
REQ-023 Each frame SHALL issue exactly one fifo_rd_en pulse.
REQ-024 fifo_rd_en is never asserted outside FETCH, and never while fifo_empty was sampled high in IDLE.
REQ-025 enable deasserted mid-fetch or mid-frame: complete the current frame, then hold IDLE.
REQ-026 fifo_empty changes outside IDLE are ignored.
REQ-027 Timer and bit-index width = max(1, clog2(CLKS_PER_BIT)) and clog2(DATA_W); no overflow at CLKS_PER_BIT=1.

Reset
REQ-028 On reset assertion, outputs SHALL immediately become: tx=1, fifo_rd_en=0, busy=0, tx_done=0.
REQ-029 On reset assertion, the FSM goes to IDLE and the counters and shift register clear to 0.
REQ-030 Reset mid-frame abandons the frame; the byte already read is lost and is not re-read.
REQ-031 After reset release, the first possible fifo_rd_en is on the second edge.

Structure
REQ-032 Shared package fifo_tx_pkg SHALL hold the state encoding localparams (3-bit) and the START_BIT/STOP_BIT constants.
REQ-033 The bit timer SHALL be a sub-module bit_timer (inputs clk, reset, run; output tick on count CLKS_PER_BIT-1).
REQ-034 Everything else stays in fifo_serial_tx.

Verification (CLKS_PER_BIT=4, DATA_W=8 unless stated)
REQ-035 FIFO holds 0xA1, enable=1 -> one rd_en pulse; tx = 0, 1,0,0,0,0,1,0,1, 1, each bit 4 cycles; single tx_done; busy high 43 cycles.
REQ-036 FIFO holds 0xB2 then 0xC3 -> two frames, two rd_en pulses, exactly 3 tx-high cycles between frames, decoded bytes B2, C3.
REQ-037 fifo_empty=1 for 200 cycles with enable=1 -> fifo_rd_en never high, tx constantly 1, busy 0.
REQ-038 enable dropped during DATA of 0xD4 with 0xE5 queued -> 0xD4 completes, 0xE5 is not read until enable returns; then 0xE5 is sent.
REQ-039 Reset asserted during bit 3 of 0xF6 -> tx=1 and busy=0 in the same cycle; no tx_done; the next frame sends the next FIFO byte.
REQ-040 CLKS_PER_BIT=1, byte 0x55 -> 10-cycle frame 0,1,0,1,0,1,0,1,0,1; tx_done on the final cycle.
